reg_writeback_unit: RTL

- Write-side counterpart of the 64-bit register file: gathers results from the ALU and the load unit, queues them, and drives the register file's rd / reg_write / write_data port at one write per cycle.
- Applies load-size sign/zero extension and suppresses writes to x0.
- Keeps a per-register pending-write scoreboard (busy) that decode uses to stall on RAW hazards.

---
 rtl/reg_writeback_unit_if.sv | 39 +++
 rtl/reg_writeback_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit_if.sv
// Bus bundle for the register writeback unit: ALU/load result inputs,
// register-file write port and the pending-write scoreboard outputs.
interface reg_writeback_unit_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;
  logic            alu_ready;

  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [1:0]      ld_size;
  logic            ld_unsigned;
  logic            ld_ready;

  logic            reg_write;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [31:0]     busy;
  logic            sb_overflow;

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
    output alu_ready, ld_ready,
    output reg_write, rd, write_data, busy, sb_overflow
  );

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
    input  alu_ready, ld_ready,
    input  reg_write, rd, write_data, busy, sb_overflow
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register-file writeback: queues ALU and load results (loads extended at push),
// drains one write per cycle, and tracks outstanding writes per register.
module reg_writeback_unit #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_unit_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int SW = CNTW + 2;
  localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [SW-1:0]   SUM_ONE = SW'(1);
  localparam logic [SW-1:0]   SUM_MAX = {2'b00, CNT_MAX};

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  function automatic logic [XLEN-1:0] extend_load(
    input logic [XLEN-1:0] raw,
    input logic [1:0]      size,
    input logic            uns
  );
    logic [XLEN-1:0] ext;
    case (size)
      2'b00: ext = uns ? {{(XLEN-8){1'b0}}, raw[7:0]}
                       : {{(XLEN-8){raw[7]}}, raw[7:0]};
      2'b01: ext = uns ? {{(XLEN-16){1'b0}}, raw[15:0]}
                       : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'b10: ext = uns ? {{(XLEN-32){1'b0}}, raw[31:0]}
                       : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  entry_t [DEPTH-1:0]     mem_q, mem_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [31:0][CNTW-1:0]  cnt_q, cnt_d;
  logic                   sb_overflow_q, sb_overflow_d;
  logic                   reg_write_q, reg_write_d;
  logic [4:0]             rd_q, rd_d;
  logic [XLEN-1:0]        write_data_q, write_data_d;

  logic                   full_s;
  logic                   empty_s;
  logic                   push_ld_s;
  logic                   push_alu_s;
  logic                   pop_s;
  entry_t                 push_entry_s;
  entry_t                 head_s;
  logic [31:0]            busy_s;
  logic [SW-1:0]          sum_v;

  // Occupancy flags and the accept/push decisions; loads win arbitration.
  always_comb begin
    full_s       = ((wptr_q - rptr_q) == DEPTH_P);
    empty_s      = (wptr_q == rptr_q);
    push_ld_s    = bus.ld_valid && !full_s && (bus.ld_rd != 5'd0);
    push_alu_s   = bus.alu_valid && !full_s && !bus.ld_valid && (bus.alu_rd != 5'd0);
    pop_s        = !empty_s;
    head_s       = mem_q[rptr_q[AW-1:0]];
    push_entry_s = '0;
    if (push_ld_s) begin
      push_entry_s.rd   = bus.ld_rd;
      push_entry_s.data = extend_load(bus.ld_data, bus.ld_size, bus.ld_unsigned);
    end else if (push_alu_s) begin
      push_entry_s.rd   = bus.alu_rd;
      push_entry_s.data = bus.alu_result;
    end else begin
      push_entry_s = '0;
    end
  end

  assign bus.ld_ready  = !full_s;
  assign bus.alu_ready = !full_s && !bus.ld_valid;

  // FIFO storage and pointers; the drain stage pops the head every non-empty cycle.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ld_s || push_alu_s) begin
      mem_d[wptr_q[AW-1:0]] = push_entry_s;
      wptr_d                = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Register-file port holds its last address/data when no write is issued.
  always_comb begin
    reg_write_d  = pop_s;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (pop_s) begin
      rd_d         = head_s.rd;
      write_data_d = head_s.data;
    end else begin
      rd_d         = rd_q;
      write_data_d = write_data_q;
    end
  end

  // Pending counters: +1 per ALU push / load issue, -1 when the write is issued;
  // the sum is formed two bits wider so a double increment can be detected.
  always_comb begin
    cnt_d         = cnt_q;
    sb_overflow_d = sb_overflow_q;
    sum_v         = '0;
    cnt_d[0]      = '0;
    for (int r = 1; r < 32; r++) begin
      sum_v = {2'b00, cnt_q[r]};
      if (push_alu_s && (bus.alu_rd == 5'(r))) begin
        sum_v = sum_v + SUM_ONE;
      end else begin
        sum_v = sum_v;
      end
      if (bus.ld_issue && (bus.ld_issue_rd == 5'(r))) begin
        sum_v = sum_v + SUM_ONE;
      end else begin
        sum_v = sum_v;
      end
      if (pop_s && (head_s.rd == 5'(r)) && (sum_v != '0)) begin
        sum_v = sum_v - SUM_ONE;
      end else begin
        sum_v = sum_v;
      end
      if (sum_v > SUM_MAX) begin
        cnt_d[r]      = CNT_MAX;
        sb_overflow_d = 1'b1;
      end else begin
        cnt_d[r] = sum_v[CNTW-1:0];
      end
    end
  end

  always_comb begin
    busy_s    = '0;
    busy_s[0] = 1'b0;
    for (int r = 1; r < 32; r++) begin
      busy_s[r] = (cnt_q[r] != '0);
    end
  end

  assign bus.busy        = busy_s;
  assign bus.reg_write   = reg_write_q;
  assign bus.rd          = rd_q;
  assign bus.write_data  = write_data_q;
  assign bus.sb_overflow = sb_overflow_q;

  // State register; reset discards queued entries and any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      sb_overflow_q <= 1'b0;
      reg_write_q   <= 1'b0;
      rd_q          <= 5'd0;
      write_data_q  <= '0;
    end else begin
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      sb_overflow_q <= sb_overflow_d;
      reg_write_q   <= reg_write_d;
      rd_q          <= rd_d;
      write_data_q  <= write_data_d;
    end
  end

endmodule
